// File: rtl/riscv_pkg.sv
// riscv_pkg: shared opcodes, register width, pipe_ctrl state encoding and control words
// Stage-control words pack as {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, mem_wb_en, mem_wb_flush}.
package riscv_pkg;
   localparam int REG_NUM_W = 5;
   localparam logic [6:0] OP_LOAD = 7'b0000011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL = 7'b1101111;
   localparam logic [1:0] RUN = 2'd0;
   localparam logic [1:0] MEM_WAIT = 2'd1;
   localparam logic [1:0] HALT = 2'd2;
   typedef struct packed {
      logic pc_en;
      logic if_id_en;
      logic if_id_flush;
      logic id_ex_en;
      logic id_ex_flush;
      logic ex_mem_en;
      logic mem_wb_en;
      logic mem_wb_flush;
   } ctrl_t;
   localparam ctrl_t CTRL_RST = ctrl_t'(8'b0010_1001);
   localparam ctrl_t CTRL_HALT = ctrl_t'(8'b0000_0001);
   localparam ctrl_t CTRL_FRZ = ctrl_t'(8'b0000_0000);
   localparam ctrl_t CTRL_BR = ctrl_t'(8'b1111_1110);
   localparam ctrl_t CTRL_LU = ctrl_t'(8'b0001_1110);
   localparam ctrl_t CTRL_FW = ctrl_t'(8'b0111_0110);
   localparam ctrl_t CTRL_RUN = ctrl_t'(8'b1101_0110);
   function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
      return (en && v != 32'hFFFF_FFFF) ? v + 32'd1 : v;
   endfunction
endpackage

// File: rtl/pipe_ctrl_if.sv
// pipe_ctrl_if: hazard inputs and stage-control outputs between the pipeline datapath and pipe_ctrl
// master: datapath side (drives hazard/handshake inputs, receives controls); slave: pipe_ctrl.
interface pipe_ctrl_if import riscv_pkg::*; #(parameter int REG_NUM_W = riscv_pkg::REG_NUM_W);
   logic [REG_NUM_W-1:0] id_rs1_num, id_rs2_num, ex_rd_num;
   logic id_uses_rs1, id_uses_rs2, ex_is_load, ex_branch_taken, imem_ready, dmem_req, dmem_ready;
   logic pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, mem_wb_en, mem_wb_flush, halted;
   modport master(
      output id_rs1_num, id_rs2_num, ex_rd_num, id_uses_rs1, id_uses_rs2, ex_is_load, ex_branch_taken,
      output imem_ready, dmem_req, dmem_ready,
      input pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, mem_wb_en, mem_wb_flush, halted
   );
   modport slave(
      input id_rs1_num, id_rs2_num, ex_rd_num, id_uses_rs1, id_uses_rs2, ex_is_load, ex_branch_taken,
      input imem_ready, dmem_req, dmem_ready,
      output pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, mem_wb_en, mem_wb_flush, halted
   );
endinterface

// File: rtl/hazard_cmp.sv
// hazard_cmp: combinational load-use compare between the ID sources and the EX load destination
// Ports: rs1_num/rs2_num/uses_rs1/uses_rs2 from ID, rd_num/is_load from EX, load_use out.
module hazard_cmp #(parameter int REG_NUM_W = 5) (
   input logic [REG_NUM_W-1:0] rs1_num,
   input logic [REG_NUM_W-1:0] rs2_num,
   input logic uses_rs1,
   input logic uses_rs2,
   input logic [REG_NUM_W-1:0] rd_num,
   input logic is_load,
   output logic load_use
);
   assign load_use = is_load && rd_num != '0 && ((uses_rs1 && rs1_num == rd_num) || (uses_rs2 && rs2_num == rd_num));
endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline sequencer producing stage enables/flushes with memory-wait freeze and timeout halt
// Ports: clk, rst (async active-low), bus (pipe_ctrl_if.slave: hazard inputs, stage controls, halted).
// Optional PIPE_CTRL_PERF_EN adds stall_cnt, flush_cnt, wait_cnt_total saturating counters.
module pipe_ctrl import riscv_pkg::*; #(
   parameter int MEM_TIMEOUT = 15,
   parameter int REG_NUM_W = riscv_pkg::REG_NUM_W
) (
   input logic clk,
   input logic rst,
   pipe_ctrl_if.slave bus
`ifdef PIPE_CTRL_PERF_EN
   ,
   output logic [31:0] stall_cnt,
   output logic [31:0] flush_cnt,
   output logic [31:0] wait_cnt_total
`endif
);
   logic [1:0] state;
   logic [7:0] wait_cnt;
   logic load_use, mem_stall, wait_done, freeze;
   ctrl_t ctrl;
   hazard_cmp #(.REG_NUM_W(REG_NUM_W)) u_hazard (
      .rs1_num(bus.id_rs1_num),
      .rs2_num(bus.id_rs2_num),
      .uses_rs1(bus.id_uses_rs1),
      .uses_rs2(bus.id_uses_rs2),
      .rd_num(bus.ex_rd_num),
      .is_load(bus.ex_is_load),
      .load_use(load_use)
   );
   always_comb begin
      mem_stall = state == RUN && bus.dmem_req && !bus.dmem_ready;
      wait_done = state == MEM_WAIT && (bus.dmem_ready || !bus.dmem_req);
      freeze = mem_stall || (state == MEM_WAIT && !wait_done);
      ctrl = !rst ? CTRL_RST :
             state == HALT ? CTRL_HALT :
             freeze ? CTRL_FRZ :
             bus.ex_branch_taken ? CTRL_BR :
             load_use ? CTRL_LU :
             !bus.imem_ready ? CTRL_FW : CTRL_RUN;
   end
   assign {bus.pc_en, bus.if_id_en, bus.if_id_flush, bus.id_ex_en, bus.id_ex_flush,
           bus.ex_mem_en, bus.mem_wb_en, bus.mem_wb_flush} = ctrl;
   assign bus.halted = state == HALT;
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= RUN;
         wait_cnt <= '0;
      end else if (mem_stall) begin
         state <= MEM_WAIT;
         wait_cnt <= 8'd1;
      end else if (wait_done) begin
         state <= RUN;
         wait_cnt <= '0;
      end else if (state == MEM_WAIT) begin
         state <= wait_cnt == 8'(MEM_TIMEOUT) ? HALT : MEM_WAIT;
         wait_cnt <= wait_cnt == 8'hFF ? wait_cnt : wait_cnt + 8'd1;
      end
   end
`ifdef PIPE_CTRL_PERF_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stall_cnt <= '0;
         flush_cnt <= '0;
         wait_cnt_total <= '0;
      end else begin
         stall_cnt <= sat_inc(stall_cnt, ctrl == CTRL_LU);
         flush_cnt <= sat_inc(flush_cnt, ctrl == CTRL_BR);
         wait_cnt_total <= sat_inc(wait_cnt_total, state == MEM_WAIT);
      end
   end
`endif
endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed bench for pipe_ctrl with a spec-level model checked every cycle
// Two instances share stimulus: dut_a (MEM_TIMEOUT=15) and dut_b (MEM_TIMEOUT=3).
module tb_pipe_ctrl;
   localparam logic [8:0] E_RST = 9'b001010010;
   localparam logic [8:0] E_RUN = 9'b110101100;
   localparam logic [8:0] E_LU = 9'b000111100;
   localparam logic [8:0] E_BR = 9'b111111100;
   localparam logic [8:0] E_FW = 9'b011101100;
   localparam logic [8:0] E_FRZ = 9'b000000000;
   localparam logic [8:0] E_HALT = 9'b000000011;
   logic clk = 1'b0;
   logic rst = 1'b0;
   logic [4:0] rs1 = '0, rs2 = '0, rd = '0;
   logic u1 = 0, u2 = 0, ld = 0, br = 0, imr = 1, dreq = 0, drdy = 0;
   int n_vec = 0, n_bad = 0;
   int tmo [2] = '{15, 3};
   bit m_wait [2];
   bit m_halt [2];
   int m_cnt [2];
   pipe_ctrl_if bus_a ();
   pipe_ctrl_if bus_b ();
   assign {bus_a.id_rs1_num, bus_a.id_rs2_num, bus_a.ex_rd_num, bus_a.id_uses_rs1, bus_a.id_uses_rs2, bus_a.ex_is_load,
           bus_a.ex_branch_taken, bus_a.imem_ready, bus_a.dmem_req, bus_a.dmem_ready} = {rs1, rs2, rd, u1, u2, ld, br, imr, dreq, drdy};
   assign {bus_b.id_rs1_num, bus_b.id_rs2_num, bus_b.ex_rd_num, bus_b.id_uses_rs1, bus_b.id_uses_rs2, bus_b.ex_is_load,
           bus_b.ex_branch_taken, bus_b.imem_ready, bus_b.dmem_req, bus_b.dmem_ready} = {rs1, rs2, rd, u1, u2, ld, br, imr, dreq, drdy};
   wire [8:0] va = {bus_a.pc_en, bus_a.if_id_en, bus_a.if_id_flush, bus_a.id_ex_en, bus_a.id_ex_flush,
                    bus_a.ex_mem_en, bus_a.mem_wb_en, bus_a.mem_wb_flush, bus_a.halted};
   wire [8:0] vb = {bus_b.pc_en, bus_b.if_id_en, bus_b.if_id_flush, bus_b.id_ex_en, bus_b.id_ex_flush,
                    bus_b.ex_mem_en, bus_b.mem_wb_en, bus_b.mem_wb_flush, bus_b.halted};
`ifdef PIPE_CTRL_PERF_EN
   logic [31:0] sa, fa, wa, sb, fb, wb;
`endif
   pipe_ctrl #(.MEM_TIMEOUT(15)) dut_a (
      .clk(clk), .rst(rst), .bus(bus_a)
`ifdef PIPE_CTRL_PERF_EN
      , .stall_cnt(sa), .flush_cnt(fa), .wait_cnt_total(wa)
`endif
   );
   pipe_ctrl #(.MEM_TIMEOUT(3)) dut_b (
      .clk(clk), .rst(rst), .bus(bus_b)
`ifdef PIPE_CTRL_PERF_EN
      , .stall_cnt(sb), .flush_cnt(fb), .wait_cnt_total(wb)
`endif
   );
   always #5 clk = ~clk;
   function automatic logic [8:0] model_out(input int i);
      bit hz = ld && rd != 0 && ((u1 && rs1 == rd) || (u2 && rs2 == rd));
      if (!rst) return E_RST;
      if (m_halt[i]) return E_HALT;
      if (dreq && !drdy) return E_FRZ;
      if (br) return E_BR;
      if (hz) return E_LU;
      if (!imr) return E_FW;
      return E_RUN;
   endfunction
   always @(negedge clk) begin
      logic [8:0] e, a;
      for (int i = 0; i < 2; i++) begin
         e = model_out(i);
         a = i == 0 ? va : vb;
         n_vec++;
         if (a !== e) begin
            n_bad++;
            $display("FAIL model dut%0d t=%0t got %b want %b", i, $time, a, e);
         end
         if (!rst) begin
            m_wait[i] = 0;
            m_halt[i] = 0;
            m_cnt[i] = 0;
         end else if (!m_halt[i]) begin
            if (dreq && !drdy) begin
               if (!m_wait[i]) begin
                  m_wait[i] = 1;
                  m_cnt[i] = 1;
               end else if (m_cnt[i] == tmo[i]) m_halt[i] = 1;
               else m_cnt[i]++;
            end else begin
               m_wait[i] = 0;
               m_cnt[i] = 0;
            end
         end
      end
   end
   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
      n_vec++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s got %0h want %0h", nm, got, want);
      end
   endtask
   task automatic step(input string nm, input int sel, input logic [8:0] want);
      @(negedge clk);
      #1;
      chk(nm, 32'(sel == 0 ? va : vb), 32'(want));
      @(posedge clk);
      #1;
   endtask
   task automatic idle();
      {rs1, rs2, rd, u1, u2, ld, br, dreq, drdy} = '0;
      imr = 1;
   endtask
   initial begin
      repeat (3) step("reset", 0, E_RST);
      rst = 1;
      step("release", 0, E_RUN);
      ld = 1; rd = 5; rs2 = 5; u2 = 1;
      step("load_use_rs2", 0, E_LU);
      ld = 0;
      step("load_use_clear", 0, E_RUN);
      ld = 1; rd = 0; rs2 = 0;
      step("rd_zero", 0, E_RUN);
      rd = 7; rs1 = 7; u1 = 1; u2 = 0;
      step("load_use_rs1", 0, E_LU);
      idle();
      ld = 1; rd = 5; rs2 = 5; u2 = 1; br = 1;
      step("branch_over_lu", 0, E_BR);
      imr = 0;
      step("branch_over_fetch", 0, E_BR);
      idle();
      imr = 0;
      step("fetch_wait", 0, E_FW);
      idle();
      dreq = 1;
      step("freeze1", 0, E_FRZ);
      br = 1;
      step("freeze2", 0, E_FRZ);
      step("freeze3", 0, E_FRZ);
      step("freeze4", 0, E_FRZ);
      step("b_halt_t4", 1, E_HALT);
      drdy = 1;
      step("resume_branch", 0, E_BR);
      idle();
      step("after_resume", 0, E_RUN);
      dreq = 1;
      step("proto_freeze", 0, E_FRZ);
      dreq = 0;
      step("proto_drop", 0, E_RUN);
      rst = 0;
      step("b_reset", 1, E_RST);
      rst = 1;
      step("b_run", 1, E_RUN);
      dreq = 1;
      repeat (4) step("b_freeze", 1, E_FRZ);
      step("b_halt", 1, E_HALT);
      drdy = 1;
      step("b_halt_rdy", 1, E_HALT);
      idle();
      step("b_halt_idle", 1, E_HALT);
      rst = 0;
      step("b_reset2", 1, E_RST);
      rst = 1;
      step("b_run2", 1, E_RUN);
      ld = 1; rd = 5; rs2 = 5; u2 = 1;
      step("perf_lu1", 0, E_LU);
      ld = 0;
      step("perf_gap", 0, E_RUN);
      ld = 1;
      step("perf_lu2", 0, E_LU);
      ld = 0; br = 1;
      step("perf_br", 0, E_BR);
      idle();
      dreq = 1;
      repeat (4) step("perf_freeze", 0, E_FRZ);
      drdy = 1;
      step("perf_resume", 0, E_RUN);
      idle();
      step("perf_idle", 0, E_RUN);
`ifdef PIPE_CTRL_PERF_EN
      chk("stall_cnt", sa, 32'd2);
      chk("flush_cnt", fa, 32'd1);
      chk("wait_cnt_total", wa, 32'd4);
`endif
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
- Central sequencer for the five-stage if_id / id_ex / ex_mem / mem_wb pipeline.
- Generates per-stage enable and flush (bubble) controls from:
  - load-use hazards,
  - taken branches/jumps resolved in EX,
  - instruction-fetch wait,
  - a valid/ready data-memory handshake.
- Owns a small FSM that freezes the whole pipe during a data-memory wait and halts the pipe on a memory timeout.

Parameters:
- MEM_TIMEOUT, 15: maximum consecutive data-memory wait cycles before entering HALT; range 1..255.
- REG_NUM_W, 5: register-number width.

Ports:
- clk  input  1  pipeline clock
- rst  input  1  asynchronous, active-low reset
- id_rs1_num  input  REG_NUM_W  source register 1 of the instruction in ID
- id_rs2_num  input  REG_NUM_W  source register 2 of the instruction in ID
- id_uses_rs1  input  1  ID instruction reads rs1
- id_uses_rs2  input  1  ID instruction reads rs2
- ex_rd_num  input  REG_NUM_W  destination register in EX (id_ex.rd_num)
- ex_is_load  input  1  EX instruction is a load (opcode 7'b0000011)
- ex_branch_taken  input  1  EX resolved a taken branch or jump
- imem_ready  input  1  instruction word valid this cycle
- dmem_req  input  1  MEM stage has an active load/store
- dmem_ready  input  1  data memory completes the access this cycle
- pc_en  output  1  PC register update enable
- if_id_en  output  1  if_id load enable
- if_id_flush  output  1  load NOP into if_id
- id_ex_en  output  1  id_ex load enable
- id_ex_flush  output  1  load bubble (opcode 0) into id_ex
- ex_mem_en  output  1  ex_mem load enable
- mem_wb_en  output  1  mem_wb load enable
- mem_wb_flush  output  1  load bubble into mem_wb
- halted  output  1  sticky timeout indication

Behaviour:
- **Reset.** While rst=0:
  - state=RUN, wait_cnt=0, halted=0.
  - All *_en=0 and all *_flush=1, so the pipe fills with bubbles.
  - Outputs follow the RUN decode from the first clk edge after rst rises.
- **State and outputs.** State is registered. All outputs are a combinational decode of state plus the current inputs, so zero-cycle response; stage registers sample on the same edge.
- **RUN, priority order:**
  1. **Memory wait:** dmem_req=1 and dmem_ready=0.
     - All *_en=0 and all flushes 0 (full freeze).
     - Next state MEM_WAIT, wait_cnt<=1.
  2. **Branch:** ex_branch_taken=1.
     - pc_en=1, if_id_flush=1, id_ex_flush=1; all other enables 1.
     - Squashes the two wrong-path instructions. Overrides load-use and imem wait.
  3. **Load-use:** ex_is_load=1, ex_rd_num!=0, and (id_uses_rs1 with id_rs1_num==ex_rd_num, or id_uses_rs2 with id_rs2_num==ex_rd_num).
     - pc_en=0, if_id_en=0, id_ex_flush=1; ex_mem_en=mem_wb_en=1.
     - Exactly one bubble; the hazard clears next cycle because the load has moved to MEM.
  4. **Fetch wait:** imem_ready=0.
     - pc_en=0, if_id_flush=1; downstream enables 1.
  5. **Otherwise:** all enables 1, all flushes 0.
- **MEM_WAIT:**
  - Full freeze. Inputs ex_branch_taken and load-use are ignored; they persist in the frozen registers and are re-evaluated on return to RUN.
  - dmem_ready=1: decode as RUN without rule 1 this cycle (the pipe advances), next state RUN, wait_cnt<=0.
  - dmem_ready=0: wait_cnt<=wait_cnt+1 (8-bit counter, never wraps). If wait_cnt==MEM_TIMEOUT, next state HALT.
  - dmem_req dropping to 0 while waiting is a protocol error. Treat it as dmem_ready=1.
- **HALT:**
  - pc_en=0, all enables 0, mem_wb_flush=1, halted=1.
  - Left only by reset.
- **Reset mid-operation:** asynchronous and immediate. Any wait count is discarded.
- **ex_rd_num==0:** never a hazard.

Optional Feature:
- Macro: PIPE_CTRL_PERF_EN.
- **Defined:** adds outputs stall_cnt[31:0], flush_cnt[31:0] and wait_cnt_total[31:0].
  - stall_cnt increments on each load-use cycle.
  - flush_cnt increments on each branch-flush cycle.
  - wait_cnt_total increments on each MEM_WAIT cycle.
  - All are cleared by rst, saturate at 32'hFFFFFFFF, and freeze in HALT.
- **Not defined:** the ports and counters are absent; the rest of the behaviour is identical.

Decomposition:
- Shared package riscv_pkg holds:
  - opcode constants (OP_LOAD=7'b0000011, OP_BRANCH=7'b1100011, OP_JAL=7'b1101111),
  - REG_NUM_W,
  - FSM state encoding (RUN=2'd0, MEM_WAIT=2'd1, HALT=2'd2).
- One sub-module, hazard_cmp: purely combinational load-use compare producing load_use.
- Perf counters stay inline under the macro.

Test Plan:
1. **Reset release:** hold rst=0 for 3 cycles, then release → during reset all *_en=0 and all flushes=1; first cycle after release with idle inputs and imem_ready=1 gives all *_en=1 and all flushes 0.
2. **Load-use:** ex_is_load=1, ex_rd_num=5, id_rs2_num=5, id_uses_rs2=1 → exactly one cycle of pc_en=0, if_id_en=0, id_ex_flush=1. Repeat with ex_rd_num=0 → no stall.
3. **Branch vs load-use:** ex_branch_taken=1 in the same cycle as test 2's hazard → if_id_flush=1, id_ex_flush=1, pc_en=1, no stall.
4. **Memory wait:** dmem_req=1, dmem_ready=0 for 4 cycles, then dmem_ready=1 → 4 full-freeze cycles and resume on the 5th. Assert ex_branch_taken during the freeze → no flush until the resume cycle.
5. **Timeout:** MEM_TIMEOUT=3, dmem_ready held 0 → HALT with halted=1 after wait_cnt reaches 3, pc_en stuck at 0 even when dmem_ready=1; rst=0 clears it.
6. **PIPE_CTRL_PERF_EN defined:** 2 load-use stalls, 1 flush and 4 wait cycles → stall_cnt=2, flush_cnt=1, wait_cnt_total=4.
